// File: rtl/branch_checkpoint_table_pkg.sv
// Shared widths, types and pointer arithmetic for the branch checkpoint table.
// Snapshots are 32 physical-register tags of 6 bits each (192 bits per slot).
package branch_checkpoint_table_pkg;

    localparam int NUM_CKPT    = 4;
    localparam int TAG_W       = $clog2(NUM_CKPT);
    localparam int RMT_ENTRIES = 32;
    localparam int PREG_W      = 6;
    localparam int SNAP_W      = RMT_ENTRIES * PREG_W;

    typedef logic [PREG_W-1:0] preg_t;
    typedef preg_t             rmt_snap_t [RMT_ENTRIES];
    typedef logic [TAG_W-1:0]  ckpt_tag_t;
    typedef logic [TAG_W:0]    ckpt_cnt_t;
    typedef logic [SNAP_W-1:0] snap_flat_t;

    // Distance of a slot from the oldest entry, modulo the ring size.
    function automatic ckpt_tag_t ckpt_age(input ckpt_tag_t slot, input ckpt_tag_t head);
        return ckpt_tag_t'(slot - head);
    endfunction

endpackage

// File: rtl/branch_checkpoint_table_if.sv
// Rename/execute-side bundle for the branch checkpoint table.
// master = rename + branch unit, slave = the table itself.
interface branch_checkpoint_table_if;
    import branch_checkpoint_table_pkg::*;

    logic      ext_stall;
    logic      ext_flush;
    logic      alloc_valid;
    rmt_snap_t checkpointed_rmt;
    ckpt_tag_t alloc_tag;
    logic      full;
    logic      resolve_valid;
    ckpt_tag_t resolve_tag;
    logic      resolve_mispred;
    logic      if_recall;
    rmt_snap_t recalled_rmt;

    modport master (
        output ext_stall, ext_flush, alloc_valid, checkpointed_rmt,
               resolve_valid, resolve_tag, resolve_mispred,
        input  alloc_tag, full, if_recall, recalled_rmt
    );

    modport slave (
        input  ext_stall, ext_flush, alloc_valid, checkpointed_rmt,
               resolve_valid, resolve_tag, resolve_mispred,
        output alloc_tag, full, if_recall, recalled_rmt
    );

endinterface

// File: rtl/branch_checkpoint_table_ckpt_snapshot_ram.sv
// Snapshot storage: one write port, one registered read port, read data 1 cycle after rd_en.
// No backpressure; read register clears on reset and otherwise holds the last read.
module ckpt_snapshot_ram
    import branch_checkpoint_table_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  ckpt_tag_t  wr_addr,
    input  snap_flat_t wr_data,
    input  logic       rd_en,
    input  ckpt_tag_t  rd_addr,
    output snap_flat_t rd_data
);

    snap_flat_t mem [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/branch_checkpoint_table.sv
// Circular table of RMT snapshots for in-flight branches; recall pulses 1 cycle after a mispredict.
// Allocation is refused while full or stalled; resolve, retire and recall are never stalled.
module branch_checkpoint_table
    import branch_checkpoint_table_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    branch_checkpoint_table_if.slave  bus
);

    ckpt_tag_t             head;
    ckpt_tag_t             tail;
    ckpt_cnt_t             count;
    logic [NUM_CKPT-1:0]   valid;
    logic [NUM_CKPT-1:0]   valid_nxt;
    logic [NUM_CKPT-1:0]   kill_mask;
    logic                  if_recall_q;
    logic                  full;
    logic                  tag_valid;
    logic                  mispred;
    logic                  correct;
    logic                  alloc_fire;
    logic                  retire;
    snap_flat_t            snap_wr;
    snap_flat_t            snap_rd;

    assign full          = (count == ckpt_cnt_t'(NUM_CKPT));
    assign bus.full      = full;
    assign bus.alloc_tag = tail;
    assign bus.if_recall = if_recall_q;

    // Flush overrides every other event, so it gates all of them here.
    assign tag_valid  = valid[bus.resolve_tag];
    assign mispred    = bus.resolve_valid &  bus.resolve_mispred & tag_valid & ~bus.ext_flush;
    assign correct    = bus.resolve_valid & ~bus.resolve_mispred & tag_valid & ~bus.ext_flush;
    assign alloc_fire = bus.alloc_valid & ~full & ~bus.ext_stall & ~mispred & ~bus.ext_flush;
    assign retire     = (count != '0) & ~valid[head] & ~mispred & ~bus.ext_flush;

    // Mispredicted branch and everything younger: measured by age from head so a
    // completely full ring (tail == head) still squashes the whole tail end.
    always_comb begin
        kill_mask = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            kill_mask[i] = (ckpt_age(ckpt_tag_t'(i), head) >= ckpt_age(bus.resolve_tag, head));
        end
    end

    always_comb begin
        valid_nxt = valid;
        if (correct) begin
            valid_nxt[bus.resolve_tag] = 1'b0;
        end
        if (alloc_fire) begin
            valid_nxt[tail] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.ext_flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            valid       <= '0;
            if_recall_q <= 1'b0;
        end else begin
            if_recall_q <= mispred;
            if (mispred) begin
                valid <= valid & ~kill_mask;
                tail  <= bus.resolve_tag;
                count <= {1'b0, ckpt_age(bus.resolve_tag, head)};
            end else begin
                valid <= valid_nxt;
                if (alloc_fire) begin
                    tail <= tail + ckpt_tag_t'(1);
                end
                if (retire) begin
                    head <= head + ckpt_tag_t'(1);
                end
                count <= count + ckpt_cnt_t'(alloc_fire) - ckpt_cnt_t'(retire);
            end
        end
    end

    for (genvar g = 0; g < RMT_ENTRIES; g++) begin : g_pack
        assign snap_wr[g*PREG_W +: PREG_W] = bus.checkpointed_rmt[g];
        assign bus.recalled_rmt[g]         = snap_rd[g*PREG_W +: PREG_W];
    end

    ckpt_snapshot_ram u_snap_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (alloc_fire),
        .wr_addr (tail),
        .wr_data (snap_wr),
        .rd_en   (mispred),
        .rd_addr (bus.resolve_tag),
        .rd_data (snap_rd)
    );

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Directed bench for branch_checkpoint_table: alloc/full, mispredict recall, retire order,
// wrap, flush priority and reset priority, each checked with immediate assertions.
module tb_branch_checkpoint_table;
    import branch_checkpoint_table_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   pass_cnt = 0;

    branch_checkpoint_table_if bus ();

    branch_checkpoint_table dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry i holds v+i-5 (mod 64) so entry 5 carries the marker value v.
    task automatic set_snap(input int v);
        for (int i = 0; i < RMT_ENTRIES; i++) begin
            bus.checkpointed_rmt[i] = preg_t'(v + i - 5);
        end
    endtask

    task automatic idle();
        bus.ext_stall       = 1'b0;
        bus.ext_flush       = 1'b0;
        bus.alloc_valid     = 1'b0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_tag     = '0;
        bus.resolve_mispred = 1'b0;
    endtask

    task automatic mispredict(input int tag);
        bus.resolve_valid   = 1'b1;
        bus.resolve_mispred = 1'b1;
        bus.resolve_tag     = ckpt_tag_t'(tag);
    endtask

    task automatic resolve_ok(input int tag);
        bus.resolve_valid   = 1'b1;
        bus.resolve_mispred = 1'b0;
        bus.resolve_tag     = ckpt_tag_t'(tag);
    endtask

    initial begin
        idle();
        set_snap(0);
        tick();
        tick();
        reset = 1'b0;

        check("reset_if_recall", 32'(bus.if_recall), 0);
        check("reset_recalled5", 32'(bus.recalled_rmt[5]), 0);
        check("reset_alloc_tag", 32'(bus.alloc_tag), 0);
        check("reset_full", 32'(bus.full), 0);
        check("reset_count", 32'(dut.count), 0);

        for (int k = 0; k < 4; k++) begin
            set_snap(40 + k);
            bus.alloc_valid = 1'b1;
            check("alloc_tag_seq", 32'(bus.alloc_tag), 32'(k));
            tick();
        end
        check("full_after_4", 32'(bus.full), 1);
        check("count_after_4", 32'(dut.count), 4);

        set_snap(99);
        tick();
        bus.alloc_valid = 1'b0;
        check("alloc_full_tag", 32'(bus.alloc_tag), 0);
        check("alloc_full_count", 32'(dut.count), 4);

        mispredict(1);
        tick();
        idle();
        check("mp1_if_recall", 32'(bus.if_recall), 1);
        check("mp1_recalled5", 32'(bus.recalled_rmt[5]), 41);
        check("mp1_recalled31", 32'(bus.recalled_rmt[31]), 3);
        check("mp1_tail", 32'(bus.alloc_tag), 1);
        check("mp1_count", 32'(dut.count), 1);
        check("mp1_full", 32'(bus.full), 0);
        tick();
        check("mp1_pulse_end", 32'(bus.if_recall), 0);

        set_snap(50);
        bus.alloc_valid = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        check("realloc_tag", 32'(bus.alloc_tag), 2);
        check("realloc_count", 32'(dut.count), 2);

        resolve_ok(1);
        tick();
        check("res1_head", 32'(dut.head), 0);
        resolve_ok(0);
        tick();
        idle();
        check("res0_head", 32'(dut.head), 0);
        tick();
        check("retire1_head", 32'(dut.head), 1);
        check("retire1_count", 32'(dut.count), 1);
        tick();
        check("retire2_head", 32'(dut.head), 2);
        check("retire2_count", 32'(dut.count), 0);
        tick();
        check("empty_head_hold", 32'(dut.head), 2);

        bus.ext_flush = 1'b1;
        tick();
        idle();
        check("flush_head", 32'(dut.head), 0);
        check("flush_tail", 32'(bus.alloc_tag), 0);

        set_snap(60);
        bus.alloc_valid = 1'b1;
        tick();
        check("a0_count", 32'(dut.count), 1);
        set_snap(61);
        mispredict(0);
        tick();
        idle();
        check("amp_tail", 32'(bus.alloc_tag), 0);
        check("amp_count", 32'(dut.count), 0);
        check("amp_if_recall", 32'(bus.if_recall), 1);
        check("amp_recalled5", 32'(bus.recalled_rmt[5]), 60);

        for (int i = 0; i < 6; i++) begin
            set_snap(i);
            bus.alloc_valid = 1'b1;
            tick();
            bus.alloc_valid = 1'b0;
            resolve_ok(i % 4);
            tick();
            idle();
            tick();
        end
        check("wrap_alloc_tag", 32'(bus.alloc_tag), 2);
        check("wrap_count", 32'(dut.count), 0);
        check("wrap_head", 32'(dut.head), 2);

        set_snap(30);
        bus.alloc_valid = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        check("wrap_alloc_next", 32'(bus.alloc_tag), 3);
        mispredict(1);
        tick();
        idle();
        check("freed_mp_recall", 32'(bus.if_recall), 0);
        check("freed_mp_tail", 32'(bus.alloc_tag), 3);
        check("freed_mp_count", 32'(dut.count), 1);

        bus.ext_flush = 1'b1;
        mispredict(2);
        tick();
        idle();
        check("flush_mp_recall", 32'(bus.if_recall), 0);
        check("flush_mp_count", 32'(dut.count), 0);
        check("flush_mp_tail", 32'(bus.alloc_tag), 0);

        bus.ext_stall = 1'b1;
        bus.alloc_valid = 1'b1;
        tick();
        idle();
        check("stall_alloc_tag", 32'(bus.alloc_tag), 0);

        for (int k = 0; k < 4; k++) begin
            set_snap(10 + k);
            bus.alloc_valid = 1'b1;
            tick();
        end
        bus.alloc_valid = 1'b0;
        check("full2", 32'(bus.full), 1);
        mispredict(0);
        tick();
        idle();
        check("mphead_count", 32'(dut.count), 0);
        check("mphead_full", 32'(bus.full), 0);
        check("mphead_tail", 32'(bus.alloc_tag), 0);
        check("mphead_if_recall", 32'(bus.if_recall), 1);
        check("mphead_recalled5", 32'(bus.recalled_rmt[5]), 10);

        for (int k = 0; k < 2; k++) begin
            set_snap(20 + k);
            bus.alloc_valid = 1'b1;
            tick();
        end
        bus.alloc_valid = 1'b0;
        mispredict(1);
        tick();
        check("pre_rst_if_recall", 32'(bus.if_recall), 1);
        check("pre_rst_recalled5", 32'(bus.recalled_rmt[5]), 21);
        reset = 1'b1;
        mispredict(0);
        tick();
        check("rst_if_recall", 32'(bus.if_recall), 0);
        check("rst_recalled5", 32'(bus.recalled_rmt[5]), 0);
        check("rst_count", 32'(dut.count), 0);
        reset = 1'b0;
        idle();
        tick();
        check("post_rst_if_recall", 32'(bus.if_recall), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
